// File: rtl/fantasy_pkg.sv
// Shared definitions for the output-mode control path: mode codes,
// sequencer FSM encoding and the status LED mapping.
package fantasy_pkg;

   typedef logic [2:0] mode_t;

   localparam mode_t DIRECT    = 3'd0;
   localparam mode_t INV       = 3'd1;
   localparam mode_t BLK_DARK  = 3'd2;
   localparam mode_t BLK_LIGHT = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // target equals committed mode, no lockout
      ST_PEND = 2'd1,   // target differs, waiting for the next frame tick
      ST_LOCK = 2'd2    // post-switch lockout, counting frames down
   } state_t;

   // LED layout {inv, cycle, pending, block}
   function automatic logic [3:0] led_enc(mode_t m, logic c, logic p);
      logic [3:0] led;
      case (m)
         DIRECT:    led = {1'b0, c, p, 1'b0};
         INV:       led = {1'b1, c, p, 1'b0};
         BLK_DARK:  led = {1'b0, c, p, 1'b1};
         BLK_LIGHT: led = {1'b1, c, p, 1'b1};
         default:   led = {1'b0, c, p, 1'b0};
      endcase
      return led;
   endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// Button / vsync inputs and mode / status outputs of the mode sequencer.
interface mode_sequencer_if;
   import fantasy_pkg::*;

   logic        vs_i;
   logic [3:0]  press_i;
   logic        hold_override_i;
   mode_t       mode_o;
   mode_t       mode_x_o;
   logic        pending_o;
   logic        cycle_o;
   logic [3:0]  led_o;

   modport master (
      output vs_i, press_i, hold_override_i,
      input  mode_o, mode_x_o, pending_o, cycle_o, led_o
   );

   modport slave (
      input  vs_i, press_i, hold_override_i,
      output mode_o, mode_x_o, pending_o, cycle_o, led_o
   );

endinterface

// File: rtl/frame_tick.sv
// Vsync rising-edge detector. The history flop resets high so a vsync
// that is already high when reset releases does not produce a tick.
module frame_tick (
   input  logic clk_i,
   input  logic rst_n,
   input  logic vs_i,
   output logic tick_o
);

   logic vs_q;

   // Remember last cycle's vsync level.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) vs_q <= 1'b1;
      else        vs_q <= vs_i;
   end

   assign tick_o = vs_i & ~vs_q;

endmodule

// File: rtl/mode_sequencer.sv
// Frame-synchronous display mode sequencer: buttons edit a target mode,
// which is committed only on a vsync tick, followed by a frame lockout.
// An optional auto-cycle steps the target every CYCLE_FRAMES frames.
module mode_sequencer
   import fantasy_pkg::*;
#(
   parameter int unsigned MIN_FRAMES   = 4,
   parameter int unsigned CYCLE_FRAMES = 120,
   parameter mode_t       RESET_MODE   = BLK_DARK
) (
   input  logic             vout_clk_i,
   input  logic             rst_n,
   mode_sequencer_if.slave  bus
);

   localparam int FW = $clog2(CYCLE_FRAMES);
   localparam int LW = (MIN_FRAMES == 0) ? 1 : $clog2(MIN_FRAMES + 1);
   localparam logic [FW-1:0] FCNT_LAST = FW'(CYCLE_FRAMES - 1);
   localparam logic [LW-1:0] LCNT_INIT = LW'(MIN_FRAMES);
   localparam logic [1:0]    RST_MODE2 = RESET_MODE[1:0];

   logic          tick;
   logic          wrap;
   logic          p_blk, p_inv;
   state_t        state_q, state_d;
   logic [1:0]    tgt_q, tgt_d;
   logic [1:0]    mode_q, mode_d;
   logic          cyc_q, cyc_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [LW-1:0] lcnt_q, lcnt_d;
   logic          pend_q;
   logic [3:0]    led_q;
   logic          unused_press0;

   assign unused_press0 = bus.press_i[0];
   assign p_blk = bus.press_i[1];
   assign p_inv = bus.press_i[2];

   frame_tick u_tick (
      .clk_i  (vout_clk_i),
      .rst_n  (rst_n),
      .vs_i   (bus.vs_i),
      .tick_o (tick)
   );

   // Target, auto-cycle enable and frame counter next-state.
   always_comb begin
      wrap  = tick & (fcnt_q == FCNT_LAST);
      cyc_d = cyc_q ^ bus.press_i[3];
      // A manual mode change takes the sequencer out of demo mode.
      if (cyc_q & (p_blk | p_inv)) cyc_d = 1'b0;

      fcnt_d = fcnt_q;
      if (cyc_d & ~cyc_q) fcnt_d = '0;
      else if (tick)      fcnt_d = wrap ? '0 : fcnt_q + FW'(1);

      tgt_d = tgt_q;
      if (p_blk | p_inv)     tgt_d = tgt_q ^ {p_blk, p_inv};
      else if (wrap & cyc_q) tgt_d = tgt_q + 2'd1;
   end

   // Commit FSM: commits the pre-update target on a tick, then locks out.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      lcnt_d  = lcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (tgt_d != mode_q) state_d = ST_PEND;
         end
         ST_PEND: begin
            if (tick) begin
               mode_d = tgt_q;
               if (MIN_FRAMES > 0) begin
                  lcnt_d  = LCNT_INIT;
                  state_d = ST_LOCK;
               end else begin
                  state_d = (tgt_d != tgt_q) ? ST_PEND : ST_IDLE;
               end
            end else if (tgt_d == mode_q) begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCK: begin
            if (tick) begin
               lcnt_d = lcnt_q - LW'(1);
               if (lcnt_q == LW'(1))
                  state_d = (tgt_d != mode_q) ? ST_PEND : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; status flags lag the target by one cycle.
   always_ff @(posedge vout_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         tgt_q   <= RST_MODE2;
         mode_q  <= RST_MODE2;
         cyc_q   <= 1'b0;
         fcnt_q  <= '0;
         lcnt_q  <= '0;
         pend_q  <= 1'b0;
         led_q   <= led_enc(RESET_MODE, 1'b0, 1'b0);
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         mode_q  <= mode_d;
         cyc_q   <= cyc_d;
         fcnt_q  <= fcnt_d;
         lcnt_q  <= lcnt_d;
         pend_q  <= (tgt_q != mode_q);
         led_q   <= led_enc({1'b0, mode_q}, cyc_q, tgt_q != mode_q);
      end
   end

   assign bus.mode_o    = {1'b0, mode_q};
   assign bus.mode_x_o  = bus.hold_override_i ? DIRECT : {1'b0, mode_q};
   assign bus.pending_o = pend_q;
   assign bus.cycle_o   = cyc_q;
   assign bus.led_o     = led_q;

endmodule
